// File: rtl/serial_shift_receiver.sv
// Reassembles an LSB-first serial bit stream into WIDTH-bit words on a valid/ready port.
// Optional even-parity bit after each word when SERIAL_RX_PARITY_EN is defined.
module serial_shift_receiver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SERIAL_RX_PARITY_EN
    localparam int unsigned LAST  = WIDTH;
`else
    localparam int unsigned LAST  = WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(LAST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_parity_err;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_valid_nxt;
    logic             w_overrun_nxt;
    logic             w_parity_err_nxt;

    logic             w_last;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_word;
    logic             w_word_ok;

    // Inverse of shr: new bit enters at the MSB, so the first bit ends in bit 0.
    assign w_last  = bit_valid && (r_cnt == CNT_W'(LAST));
    assign w_shift = WIDTH'({bit_in, r_sr} >> 1);

`ifdef SERIAL_RX_PARITY_EN
    // Completion is on the parity bit; the data bits are already in r_sr.
    assign w_word    = r_sr;
    assign w_word_ok = ~((^r_sr) ^ bit_in);
`else
    assign w_word    = w_shift;
    assign w_word_ok = 1'b1;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_sr_nxt         = r_sr;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid;
        w_overrun_nxt    = r_overrun;
        w_parity_err_nxt = r_parity_err;

        if (clr) begin
            w_state_nxt      = IDLE;
            w_cnt_nxt        = '0;
            w_sr_nxt         = '0;
            w_data_nxt       = '0;
            w_valid_nxt      = 1'b0;
            w_overrun_nxt    = 1'b0;
            w_parity_err_nxt = 1'b0;
        end else begin
            if (bit_valid) begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_state_nxt = SHIFT;
                end
`ifdef SERIAL_RX_PARITY_EN
                if (!w_last) begin
                    w_sr_nxt = w_shift;
                end
`else
                w_sr_nxt = w_shift;
`endif
            end

            // A completing word may be accepted in the same edge the old one is consumed.
            if (w_last && w_word_ok) begin
                if (!r_valid || data_ready) begin
                    w_data_nxt  = w_word;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_overrun_nxt = 1'b1;
                end
            end else if (r_valid && data_ready) begin
                w_valid_nxt = 1'b0;
            end

            if (w_last && !w_word_ok) begin
                w_parity_err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sr         <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sr         <= w_sr_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_overrun    <= w_overrun_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign busy       = r_state[0];
    assign overrun    = r_overrun;
`ifdef SERIAL_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_shift_receiver.sv
// Directed bench for serial_shift_receiver (WIDTH=8); parity scenario runs when SERIAL_RX_PARITY_EN is defined.
module tb_serial_shift_receiver;

    localparam int unsigned WIDTH = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             data_ready = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int total = 0;
    int bad   = 0;

    serial_shift_receiver #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = b;
        clr       = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr       = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        clr       = 1'b0;
    endtask

    // Drives one word (plus parity bit in parity builds); optionally raises data_ready on the final bit.
    task automatic send_word(input logic [7:0] w, input logic flip, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            if (i == 7 && rdy_last && !PAR) data_ready = 1'b1;
        end
        if (PAR) begin
            send_bit((^w) ^ flip);
            if (rdy_last) data_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%0h exp=0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err got=%0b exp=0", parity_err); end
        @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        idle();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midword_busy got=%0b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%0b exp=0", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%0b exp=0", data_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, 1'b0, 1'b0);
        idle();
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL post_reset_word got=%0h exp=a5", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%0b exp=1", data_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hA5;
        do_clr();
        data_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        @(posedge clk); #1;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%0b exp=0", data_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", busy); end
        send_bit(w[7]);
        if (PAR) send_bit(^w);
        idle();
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", data_valid); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL basic_data got=%0h exp=a5", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b exp=0", busy); end
    endtask

    task automatic test_overrun();
        do_clr();
        data_ready = 1'b0;
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hFF, 1'b0, 1'b0);
        idle();
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL overrun_data got=%0h exp=3c", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%0b exp=1", data_valid); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%0b exp=1", overrun); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL overrun_parity_err got=%0b exp=0", parity_err); end
        data_ready = 1'b1;
        idle();
        data_ready = 1'b0;
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL consume_valid got=%0b exp=0", data_valid); end
        total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL consume_data_hold got=%0h exp=3c", data_out); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
        do_clr();
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%0b exp=0", overrun); end
    endtask

    task automatic test_simultaneous();
        do_clr();
        data_ready = 1'b0;
        send_word(8'h12, 1'b0, 1'b0);
        send_word(8'h34, 1'b0, 1'b1);
        idle();
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%0b exp=1", data_valid); end
        total++; if (data_out !== 8'h34) begin bad++; $display("FAIL simul_data got=%0h exp=34", data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL simul_overrun got=%0b exp=0", overrun); end
        data_ready = 1'b0;
    endtask

    task automatic test_clr_gaps();
        do_clr();
        data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            idle();
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gaps_busy got=%0b exp=1", busy); end
        do_clr();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL gaps_clr_busy got=%0b exp=0", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL gaps_clr_valid got=%0b exp=0", data_valid); end
        send_word(8'h81, 1'b0, 1'b0);
        idle();
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL gaps_data got=%0h exp=81", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%0b exp=1", data_valid); end
    endtask

    task automatic test_clr_final();
        do_clr();
        data_ready = 1'b0;
        for (int i = 0; i < 7 + int'(PAR); i++) send_bit(1'b1);
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        clr       = 1'b1;
        idle();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL clr_final_valid got=%0b exp=0", data_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_final_busy got=%0b exp=0", busy); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL clr_final_data got=%0h exp=0", data_out); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        data_ready = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0);
        @(posedge clk); #1;
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%0b exp=1", data_valid); end
        total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL b2b_first_data got=%0h exp=5a", data_out); end
        send_word(8'hC3, 1'b0, 1'b0);
        idle();
        data_ready = 1'b0;
        total++; if (data_out !== 8'hC3) begin bad++; $display("FAIL b2b_second_data got=%0h exp=c3", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%0b exp=1", data_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        do_clr();
        data_ready = 1'b0;
        send_word(8'h07, 1'b0, 1'b0);
        idle();
        total++; if (data_out !== 8'h07) begin bad++; $display("FAIL parity_good_data got=%0h exp=07", data_out); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_good_err got=%0b exp=0", parity_err); end
        send_word(8'h07, 1'b1, 1'b0);
        idle();
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_bad_err got=%0b exp=1", parity_err); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL parity_bad_valid got=%0b exp=1", data_valid); end
        total++; if (data_out !== 8'h07) begin bad++; $display("FAIL parity_bad_data got=%0h exp=07", data_out); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL parity_bad_overrun got=%0b exp=0", overrun); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_simultaneous();
        test_clr_gaps();
        test_clr_final();
        test_back_to_back();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_shift_receiver.md
# serial_shift_receiver

- Receive end of the 1-bit shift-right stream produced by our shr/right_carry registers.
- Samples one qualified serial bit per clock, LSB first, and reassembles a WIDTH-bit word.
- Presents each word on a valid/ready output port and flags lost words.
- Sits between a right-shifting source register and any parallel consumer.

## Interface
- WIDTH, 8, data word width in bits (≥2).
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clr  input  1  synchronous clear, highest priority.
- bit_valid  input  1  bit_in is sampled this cycle.
- bit_in  input  1  serial data bit, LSB of the word first.
- data_ready  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  assembled word, held stable while data_valid=1.
- data_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  a word is partially received (bit count ≠ 0).
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  sticky: parity check failed (see Configuration).

## Operation
- Internal state:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt covering 0..WIDTH (0..WIDTH-1 without parity);
  - FSM states IDLE (cnt=0) and SHIFT (cnt>0);
  - output holding register plus data_valid flag.
- Per-cycle priority:
  - clr=1: sr, cnt, data_out, data_valid, overrun and parity_err all go to 0; FSM goes to IDLE; bit_valid and data_ready are ignored.
  - Otherwise, if bit_valid=1: sr <= {bit_in, sr[WIDTH-1:1]}, cnt increments, IDLE→SHIFT. This is the inverse of shr, so the first bit received lands in bit 0.
  - Otherwise sr and cnt hold.
- Word completion, without parity, when the WIDTH-th bit is sampled:
  - the completed word is {bit_in, sr[WIDTH-1:1]};
  - cnt wraps to 0, FSM goes to IDLE.
- Output port on completion:
  - data_valid=0, or data_valid=1 with data_ready=1 on the same edge: word loads into data_out, data_valid=1.
  - data_valid=1 with data_ready=0: word is dropped, overrun set to 1, and data_out is unchanged.
- Consumption:
  - data_valid=1 and data_ready=1 with no completion on that edge: data_valid goes to 0, data_out keeps its last value.
  - data_ready while data_valid=0 has no effect.
- Back-to-back words with no idle cycle between them are legal.
- busy = (cnt≠0).

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, cnt=0, FSM=IDLE.
- Latency: data_valid rises one edge after the last bit is sampled; it is a registered output.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity) with continuous bit_valid.
- Async reset mid-word discards the partial word immediately.
- clr on the same edge as the final bit: clear wins and no word is produced.
- Gaps with bit_valid=0 mid-word pause reception indefinitely; there is no timeout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - after the WIDTH data bits, one extra even-parity bit is sampled, so cnt runs 0..WIDTH;
  - completion happens on the parity bit;
  - if the XOR of the data bits and the parity bit is 1, the word is dropped and parity_err is set (sticky until clr/reset); overrun is not affected;
  - if parity is good, output handling is as above.
- Undefined:
  - no parity bit; completion happens on the WIDTH-th data bit;
  - parity_err is tied to 0.

## Test plan
- Reset: assert rst_n=0 mid-word (3 bits in), release → all outputs 0. A following full 8-bit stream of 0xA5 yields data_out=0xA5.
- Basic: WIDTH=8, bits 1,0,1,0,0,1,0,1 (0xA5 LSB first) with bit_valid continuous and data_ready=0 → data_valid=1 one edge after bit 8, data_out=0xA5, busy=0.
- Overrun: hold data_ready=0, send 0x3C then 0xFF → data_out stays 0x3C, overrun=1. data_ready=1 → data_valid=0. clr → overrun=0.
- Simultaneous: send 0x12 (data_ready=0), then 0x34, raising data_ready only on the edge where 0x34 completes → data_valid stays 1, data_out=0x34, overrun=0.
- clr mid-word plus gaps: 5 bits with bit_valid toggling, then clr, then a full 0x81 stream → data_out=0x81, no residue from the first bits.
- Parity (SERIAL_RX_PARITY_EN defined): 0x07 + parity 1 → data_out=0x07. Then 0x07 + parity 0 → word dropped, parity_err=1, data_valid unchanged.
